// File: rtl/writeback_stage_if.sv
// writeback_stage_if: MEM->WB stage bus, regfile write port and decode bypass signals.
interface writeback_stage_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
);
    logic                 InValid;
    logic                 InReady;
    logic                 Stall;
    logic                 Flush;
    logic [WIDTH-1:0]     ALUResult;
    logic [WIDTH-1:0]     MemReadData;
    logic [WIDTH-1:0]     PCPlus4;
    logic [4:0]           DestReg;
    logic                 RegWriteIn;
    logic [1:0]           MemToReg;
    logic [2:0]           LoadType;
    logic [4:0]           ReadRegister1;
    logic [4:0]           ReadRegister2;
    logic [WIDTH-1:0]     RegData1;
    logic [WIDTH-1:0]     RegData2;
    logic                 RegWrite;
    logic [4:0]           WriteRegister;
    logic [WIDTH-1:0]     WriteData;
    logic [WIDTH-1:0]     FwdData1;
    logic [WIDTH-1:0]     FwdData2;
    logic [CNT_WIDTH-1:0] RetiredCount;

    modport master (
        output InValid, Stall, Flush, ALUResult, MemReadData, PCPlus4, DestReg, RegWriteIn,
               MemToReg, LoadType, ReadRegister1, ReadRegister2, RegData1, RegData2,
        input  InReady, RegWrite, WriteRegister, WriteData, FwdData1, FwdData2, RetiredCount
    );

    modport slave (
        input  InValid, Stall, Flush, ALUResult, MemReadData, PCPlus4, DestReg, RegWriteIn,
               MemToReg, LoadType, ReadRegister1, ReadRegister2, RegData1, RegData2,
        output InReady, RegWrite, WriteRegister, WriteData, FwdData1, FwdData2, RetiredCount
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: MEM->WB register with load extraction, single-shot regfile commit and read bypass.
module writeback_stage #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
) (
    input logic              Clk,
    input logic              Reset_n,
    writeback_stage_if.slave wb
);
    logic                 valid_q, valid_d;
    logic                 committed_q, committed_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]     alu_q, mem_q, pc4_q;
    logic [4:0]           dest_q;
    logic                 rw_q;
    logic [1:0]           mtr_q;
    logic [2:0]           lt_q;
    logic                 capture, retire;
    logic [7:0]           byte_v;
    logic [15:0]          half_v;
    logic [WIDTH-1:0]     load_v;

    // committed_q marks an entry held by Stall that already wrote the regfile once
    always_comb begin
        capture     = ~wb.Flush & ~wb.Stall & wb.InValid;
        valid_d     = wb.Flush ? 1'b0 : wb.Stall ? valid_q : wb.InValid;
        committed_d = ~wb.Flush & wb.Stall & valid_q;
        retire      = valid_q & ~committed_q;
        cnt_d       = cnt_q + CNT_WIDTH'(retire);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q     <= 1'b0;
            committed_q <= 1'b0;
            cnt_q       <= '0;
            alu_q       <= '0;
            mem_q       <= '0;
            pc4_q       <= '0;
            dest_q      <= '0;
            rw_q        <= 1'b0;
            mtr_q       <= '0;
            lt_q        <= '0;
        end else begin
            valid_q     <= valid_d;
            committed_q <= committed_d;
            cnt_q       <= cnt_d;
            if (capture) begin
                alu_q  <= wb.ALUResult;
                mem_q  <= wb.MemReadData;
                pc4_q  <= wb.PCPlus4;
                dest_q <= wb.DestReg;
                rw_q   <= wb.RegWriteIn;
                mtr_q  <= wb.MemToReg;
                lt_q   <= wb.LoadType;
            end
        end
    end

    always_comb begin
        byte_v = mem_q[{alu_q[1:0], 3'b000} +: 8];
        half_v = alu_q[1] ? mem_q[31:16] : mem_q[15:0];
        load_v = (lt_q == 3'b001) ? {{24{byte_v[7]}}, byte_v} :
                 (lt_q == 3'b010) ? {24'd0, byte_v} :
                 (lt_q == 3'b011) ? {{16{half_v[15]}}, half_v} :
                 (lt_q == 3'b100) ? {16'd0, half_v} : mem_q;
    end

    assign wb.WriteData     = (mtr_q == 2'b01) ? load_v : (mtr_q == 2'b10) ? pc4_q : alu_q;
    assign wb.RegWrite      = retire & rw_q & (dest_q != 5'd0);
    assign wb.WriteRegister = valid_q ? dest_q : 5'd0;
    assign wb.FwdData1      = (wb.RegWrite && wb.ReadRegister1 != 5'd0 && wb.ReadRegister1 == wb.WriteRegister) ? wb.WriteData : wb.RegData1;
    assign wb.FwdData2      = (wb.RegWrite && wb.ReadRegister2 != 5'd0 && wb.ReadRegister2 == wb.WriteRegister) ? wb.WriteData : wb.RegData2;
    assign wb.InReady       = ~wb.Stall;
    assign wb.RetiredCount  = cnt_q;
endmodule
